// File: rtl/bf_pass_sequencer.sv
// Pass/vertex sequencer for a Bellman-Ford relaxation engine: walks every vertex once
// per pass, stops early when a pass changes nothing, and flags a negative cycle on pass N.
module bf_pass_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [12:0] num_vertices,
    input  logic [12:0] graph_base,
    output logic        relax_req,
    input  logic        relax_ack,
    input  logic        relax_updated,
    output logic [12:0] vtx,
    output logic [12:0] gm_addr,
    output logic        check_pass,
    output logic        busy,
    output logic        done,
    output logic        neg_cycle,
    output logic [12:0] pass_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        PASS_END = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [12:0] n_q, n_next;
    logic [12:0] base_q, base_next;
    logic [12:0] vtx_q, vtx_next;
    logic [12:0] pass_q, pass_next;
    logic [12:0] count_q, count_next;
    logic        dirty_q, dirty_next;
    logic        neg_q, neg_next;

    // NOTE: every target gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        n_next     = n_q;
        base_next  = base_q;
        vtx_next   = vtx_q;
        pass_next  = pass_q;
        count_next = count_q;
        dirty_next = dirty_q;
        neg_next   = neg_q;

        if (abort) begin
            state_next = IDLE;
            vtx_next   = '0;
            pass_next  = '0;
            dirty_next = 1'b0;
            count_next = '0;
            neg_next   = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        count_next = '0;
                        neg_next   = 1'b0;
                        if (num_vertices >= 13'd2) begin
                            n_next     = num_vertices;
                            base_next  = graph_base;
                            vtx_next   = '0;
                            pass_next  = 13'd1;
                            dirty_next = 1'b0;
                            state_next = REQ;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                REQ: begin
                    if (relax_ack) begin
                        dirty_next = dirty_q | relax_updated;
                        if (vtx_q == n_q - 13'd1) begin
                            state_next = PASS_END;
                        end else begin
                            vtx_next = vtx_q + 13'd1;
                        end
                    end
                end
                PASS_END: begin
                    count_next = count_q + 13'd1;
                    if (!dirty_q) begin
                        neg_next   = 1'b0;
                        state_next = DONE;
                    end else if (pass_q == n_q) begin
                        neg_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        // Reaching pass N turns this into the check pass; check_pass decodes it.
                        pass_next  = pass_q + 13'd1;
                        vtx_next   = '0;
                        dirty_next = 1'b0;
                        state_next = REQ;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            n_q     <= '0;
            base_q  <= '0;
            vtx_q   <= '0;
            pass_q  <= '0;
            count_q <= '0;
            dirty_q <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            n_q     <= n_next;
            base_q  <= base_next;
            vtx_q   <= vtx_next;
            pass_q  <= pass_next;
            count_q <= count_next;
            dirty_q <= dirty_next;
            neg_q   <= neg_next;
        end
    end

    assign relax_req  = (state == REQ);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign check_pass = ((state == REQ) || (state == PASS_END)) && (pass_q == n_q);
    assign vtx        = vtx_q;
    assign gm_addr    = base_q + vtx_q;
    assign neg_cycle  = neg_q;
    assign pass_count = count_q;

endmodule

// File: tb/tb_bf_pass_sequencer.sv
// Self-checking bench for bf_pass_sequencer: directed table, abort/reset sequences and
// randomized runs against a pass-level Bellman-Ford sequencing model.
module tb_bf_pass_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [12:0] num_vertices;
    logic [12:0] graph_base;
    logic        relax_req;
    logic        relax_ack;
    logic        relax_updated;
    logic [12:0] vtx;
    logic [12:0] gm_addr;
    logic        check_pass;
    logic        busy;
    logic        done;
    logic        neg_cycle;
    logic [12:0] pass_count;

    bf_pass_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .num_vertices (num_vertices),
        .graph_base   (graph_base),
        .relax_req    (relax_req),
        .relax_ack    (relax_ack),
        .relax_updated(relax_updated),
        .vtx          (vtx),
        .gm_addr      (gm_addr),
        .check_pass   (check_pass),
        .busy         (busy),
        .done         (done),
        .neg_cycle    (neg_cycle),
        .pass_count   (pass_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int n;
        int base;
        int upd;        // passes 1..upd report updates; later passes are clean
        int delay;      // cycles of relax_req before ack; -1 means random 0..3
        bit noise;      // stray acks plus random start/num_vertices/graph_base mid-run
        int exp_count;
        int exp_neg;
    } vec_t;

    vec_t tbl[8];

    function automatic int pick_delay(input int delay);
        return (delay >= 0) ? delay : int'($urandom_range(0, 3));
    endfunction

    // Expected behaviour: each pass visits vertices 0..N-1 once; a pass with no update
    // ends the run cleanly; a still-dirty pass N means a negative cycle.
    task automatic run_case(input int n, input int base, input int upd, input int delay,
                            input bit rnd_upd, input bit noise, input bit use_exp,
                            input int exp_count, input int exp_neg);
        int  m_vtx   = 0;
        int  m_pass  = 1;
        int  m_count = 0;
        bit  m_dirty = 1'b0;
        bit  m_neg   = 1'b0;
        int  phase;          // 0 relaxing, 1 pass end, 2 done
        int  wait_cnt;
        bit  u;
        bit  finished = 1'b0;

        phase    = (n >= 2) ? 0 : 2;
        wait_cnt = pick_delay(delay);
        start        = 1'b1;
        num_vertices = 13'(n);
        graph_base   = 13'(base);
        relax_ack    = 1'b0;

        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            @(negedge clock);
            start         = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            relax_ack     = 1'b0;
            relax_updated = 1'b0;
            if (noise) begin
                num_vertices = 13'($urandom_range(0, 8191));
                graph_base   = 13'($urandom_range(0, 8191));
            end
            check("busy", busy, 1);
            check("relax_req", relax_req, phase == 0);
            check("done", done, phase == 2);
            check("check_pass", check_pass, (phase != 2) && (m_pass == n));
            check("pass_count", pass_count, m_count);
            check("neg_cycle", neg_cycle, (phase == 2) && m_neg);
            case (phase)
                0: begin
                    check("vtx", vtx, m_vtx);
                    check("gm_addr", gm_addr, (base + m_vtx) % 8192);
                    if (wait_cnt == 0) begin
                        u = (m_pass <= upd) &&
                            (!rnd_upd || $urandom_range(0, 1) == 1 || m_vtx == n - 1);
                        relax_ack     = 1'b1;
                        relax_updated = u;
                        m_dirty       = m_dirty | u;
                        if (m_vtx == n - 1) phase = 1;
                        else m_vtx++;
                        wait_cnt = pick_delay(delay);
                    end else begin
                        wait_cnt--;
                    end
                end
                1: begin
                    if (noise) begin
                        relax_ack     = 1'($urandom_range(0, 1));
                        relax_updated = 1'b1;
                    end
                    m_count++;
                    if (!m_dirty) begin
                        m_neg = 1'b0;
                        phase = 2;
                    end else if (m_pass == n) begin
                        m_neg = 1'b1;
                        phase = 2;
                    end else begin
                        m_pass++;
                        m_vtx   = 0;
                        m_dirty = 1'b0;
                        phase   = 0;
                    end
                end
                default: begin
                    if (noise) begin
                        relax_ack     = 1'($urandom_range(0, 1));
                        relax_updated = 1'b1;
                    end
                    if (use_exp) begin
                        check("tbl_pass_count", pass_count, exp_count);
                        check("tbl_neg_cycle", neg_cycle, exp_neg);
                    end
                    finished = 1'b1;
                end
            endcase
        end
        check("run_completed", finished, 1);

        @(negedge clock);
        start     = 1'b0;
        relax_ack = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_relax_req", relax_req, 0);
        check("idle_pass_count", pass_count, m_count);
        check("idle_neg_cycle", neg_cycle, m_neg);
    endtask

    task automatic abort_sequence();
        bit hit = 1'b0;
        start        = 1'b1;
        num_vertices = 13'd4;
        graph_base   = 13'h040;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            @(negedge clock);
            start         = 1'b0;
            relax_ack     = 1'b1;
            relax_updated = 1'b1;
            if (relax_req && vtx == 13'd2 && pass_count == 13'd1) begin
                hit   = 1'b1;
                abort = 1'b1;
                start = 1'b1;
            end
        end
        check("abort_point_reached", hit, 1);
        @(negedge clock);
        abort     = 1'b0;
        start     = 1'b0;
        relax_ack = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_relax_req", relax_req, 0);
        check("abort_done", done, 0);
        check("abort_pass_count", pass_count, 0);
        check("abort_neg_cycle", neg_cycle, 0);
        @(negedge clock);
        check("abort_no_done", done, 0);
        check("abort_stays_idle", busy, 0);
        run_case(4, 'h040, 1, 0, 1'b0, 1'b0, 1'b1, 2, 0);
    endtask

    task automatic reset_sequence();
        start        = 1'b1;
        num_vertices = 13'd5;
        graph_base   = 13'h0777;
        @(negedge clock);
        start = 1'b0;
        check("rst_run_started", relax_req, 1);
        @(negedge clock);
        start = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst_relax_req", relax_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_check_pass", check_pass, 0);
        check("rst_neg_cycle", neg_cycle, 0);
        check("rst_pass_count", pass_count, 0);
        check("rst_vtx", vtx, 0);
        check("rst_gm_addr", gm_addr, 0);
        @(negedge clock);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_done", done, 0);
        check("post_rst_busy", busy, 0);
        start        = 1'b1;
        num_vertices = 13'd2;
        graph_base   = 13'h0010;
        @(negedge clock);
        start = 1'b0;
        check("first_start_req", relax_req, 1);
        check("first_start_addr", gm_addr, 'h10);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("cleanup_idle", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0] = '{4, 'h100,  1,  0, 1'b0, 2, 0};
        tbl[1] = '{3, 'h000,  3,  0, 1'b0, 3, 1};
        tbl[2] = '{5, 'h0A0,  2,  3, 1'b1, 3, 0};
        tbl[3] = '{1, 'h123,  1,  0, 1'b0, 0, 0};
        tbl[4] = '{0, 'h055,  1,  0, 1'b0, 0, 0};
        tbl[5] = '{4, 'h1FFE, 0,  0, 1'b0, 1, 0};
        tbl[6] = '{2, 'h500,  9,  1, 1'b0, 2, 1};
        tbl[7] = '{2, 'h600,  1, -1, 1'b1, 2, 0};

        reset         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        relax_ack     = 1'b0;
        relax_updated = 1'b0;
        num_vertices  = '0;
        graph_base    = '0;
        #1;
        check("reset_relax_req", relax_req, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pass_count", pass_count, 0);
        check("reset_gm_addr", gm_addr, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            run_case(tbl[i].n, tbl[i].base, tbl[i].upd, tbl[i].delay, 1'b0,
                     tbl[i].noise, 1'b1, tbl[i].exp_count, tbl[i].exp_neg);
        end

        abort_sequence();
        reset_sequence();

        for (int i = 0; i < 25; i++) begin
            n = int'($urandom_range(0, 7));
            run_case(n, int'($urandom_range(0, 8191)), int'($urandom_range(0, n + 1)), -1,
                     1'b1, 1'b1, 1'b0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
